// File: rtl/ccr_unit_if.sv
// rtl/ccr_unit_if.sv - EX-stage control/flag bundle between pipeline and CCR
interface ccr_unit_if;
  logic       stall;
  logic [3:0] alu_we;
  logic       alu_zf;
  logic       alu_nf;
  logic       alu_cf;
  logic       alu_ovf;
  logic       setc;
  logic       clrc;
  logic       br_taken;
  logic [1:0] br_sel;
  logic       int_save;
  logic       rti_restore;
  logic       zf;
  logic       nf;
  logic       cf;
  logic       ovf;
  logic [2:0] shadow_count;
  logic       stack_err;

  modport master (
    output stall, alu_we, alu_zf, alu_nf, alu_cf, alu_ovf,
    output setc, clrc, br_taken, br_sel, int_save, rti_restore,
    input  zf, nf, cf, ovf, shadow_count, stack_err
  );

  modport slave (
    input  stall, alu_we, alu_zf, alu_nf, alu_cf, alu_ovf,
    input  setc, clrc, br_taken, br_sel, int_save, rti_restore,
    output zf, nf, cf, ovf, shadow_count, stack_err
  );
endinterface

// File: rtl/ccr_unit.sv
// rtl/ccr_unit.sv - condition-code register with interrupt shadow stack
module ccr_unit #(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ccr_unit_if.slave   bus
);

  // Flag vectors are packed {ovf,cf,nf,zf}, matching the alu_we bit order.
  logic [3:0]                    flags_q, flags_d;
  logic [SHADOW_DEPTH-1:0][3:0]  stack_q, stack_d;
  logic [2:0]                    count_q, count_d;
  logic                          err_q, err_d;

  logic [3:0] alu_flags;
  logic [3:0] upd;
  logic [3:0] top;

  assign alu_flags = {bus.alu_ovf, bus.alu_cf, bus.alu_nf, bus.alu_zf};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      stack_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      stack_q <= stack_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    flags_d = flags_q;
    stack_d = stack_q;
    count_d = count_q;
    err_d   = err_q;
    upd     = flags_q;
    top     = '0;

    for (int i = 0; i < SHADOW_DEPTH; i++) begin
      if (count_q == 3'(i + 1)) top = stack_q[i];
    end

    for (int i = 0; i < 4; i++) begin
      if (bus.alu_we[i]) upd[i] = alu_flags[i];
    end
    if (bus.setc && !bus.clrc)      upd[2] = 1'b1;
    else if (bus.clrc && !bus.setc) upd[2] = 1'b0;
    if (bus.br_taken) begin
      case (bus.br_sel)
        2'd0:    upd[0] = 1'b0;
        2'd1:    upd[1] = 1'b0;
        2'd2:    upd[2] = 1'b0;
        default: ;
      endcase
    end

    // Restore outranks stall so an RTI can never be lost behind a bubble.
    if (bus.rti_restore) begin
      if (count_q != 3'd0) begin
        flags_d = top;
        count_d = count_q - 3'd1;
      end else begin
        flags_d = '0;
        err_d   = 1'b1;
      end
    end else if (!bus.stall) begin
      flags_d = upd;
      if (bus.int_save) begin
        if (count_q == 3'(SHADOW_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (count_q == 3'(i)) stack_d[i] = flags_q;
          end
          count_d = count_q + 3'd1;
        end
      end
    end
  end

  assign bus.zf           = flags_q[0];
  assign bus.nf           = flags_q[1];
  assign bus.cf           = flags_q[2];
  assign bus.ovf          = flags_q[3];
  assign bus.shadow_count = count_q;
  assign bus.stack_err    = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
// tb/tb_ccr_unit.sv - directed self-checking bench for ccr_unit
module tb_ccr_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [3:0] fl;

  ccr_unit_if bus ();

  ccr_unit #(.SHADOW_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign fl = {bus.ovf, bus.cf, bus.nf, bus.zf};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.stall       = 1'b0;
    bus.alu_we      = 4'b0000;
    {bus.alu_ovf, bus.alu_cf, bus.alu_nf, bus.alu_zf} = 4'b0000;
    bus.setc        = 1'b0;
    bus.clrc        = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_sel      = 2'd0;
    bus.int_save    = 1'b0;
    bus.rti_restore = 1'b0;
  endtask

  task automatic alu(input logic [3:0] we, input logic [3:0] v);
    bus.alu_we = we;
    {bus.alu_ovf, bus.alu_cf, bus.alu_nf, bus.alu_zf} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] v);
    idle();
    alu(4'b1111, v);
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if (fl !== 4'b0000 || bus.shadow_count !== 3'd0 || bus.stack_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: flags=%b cnt=%0d err=%b expected 0000 0 0", fl, bus.shadow_count, bus.stack_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_write();
    idle();
    alu(4'b1111, 4'b1010);
    step();
    total++;
    if (fl !== 4'b1010) begin
      bad++;
      $display("FAIL alu_write: flags=%b expected 1010", fl);
    end
    idle();
    step(); step(); step();
    total++;
    if (fl !== 4'b1010) begin
      bad++;
      $display("FAIL alu_hold: flags=%b expected 1010", fl);
    end
    alu(4'b0010, 4'b0000);
    step();
    total++;
    if (fl !== 4'b1000) begin
      bad++;
      $display("FAIL alu_mask: flags=%b expected 1000", fl);
    end
  endtask

  task automatic test_setc_clrc();
    load_flags(4'b0000);
    alu(4'b0011, 4'b1111);
    bus.setc = 1'b1;
    step();
    total++;
    if (fl !== 4'b0111) begin
      bad++;
      $display("FAIL setc_mask: flags=%b expected 0111", fl);
    end
    idle();
    alu(4'b0100, 4'b0000);
    bus.setc = 1'b1;
    bus.clrc = 1'b1;
    step();
    total++;
    if (fl !== 4'b0011) begin
      bad++;
      $display("FAIL setc_clrc_both: flags=%b expected 0011", fl);
    end
    idle();
    bus.setc = 1'b1;
    step();
    idle();
    bus.clrc = 1'b1;
    alu(4'b0100, 4'b1111);
    step();
    total++;
    if (fl !== 4'b0011) begin
      bad++;
      $display("FAIL clrc_over_alu: flags=%b expected 0011", fl);
    end
    idle();
  endtask

  task automatic test_branch();
    load_flags(4'b0101);
    bus.br_taken = 1'b1;
    bus.br_sel   = 2'd0;
    step();
    total++;
    if (fl !== 4'b0100) begin
      bad++;
      $display("FAIL br_zf: flags=%b expected 0100", fl);
    end
    bus.br_sel = 2'd3;
    step();
    total++;
    if (fl !== 4'b0100) begin
      bad++;
      $display("FAIL br_reserved: flags=%b expected 0100", fl);
    end
    bus.br_sel = 2'd2;
    bus.setc   = 1'b1;
    step();
    total++;
    if (fl !== 4'b0000) begin
      bad++;
      $display("FAIL br_cf_over_setc: flags=%b expected 0000", fl);
    end
    idle();
    alu(4'b1111, 4'b1111);
    bus.br_taken = 1'b1;
    bus.br_sel   = 2'd1;
    step();
    total++;
    if (fl !== 4'b1101) begin
      bad++;
      $display("FAIL br_nf_over_alu: flags=%b expected 1101", fl);
    end
    idle();
  endtask

  task automatic test_save_restore();
    load_flags(4'b1010);
    alu(4'b1111, 4'b0101);
    bus.int_save = 1'b1;
    step();
    total++;
    if (fl !== 4'b0101 || bus.shadow_count !== 3'd1) begin
      bad++;
      $display("FAIL save: flags=%b cnt=%0d expected 0101 1", fl, bus.shadow_count);
    end
    idle();
    bus.rti_restore = 1'b1;
    step();
    total++;
    if (fl !== 4'b1010 || bus.shadow_count !== 3'd0 || bus.stack_err !== 1'b0) begin
      bad++;
      $display("FAIL restore: flags=%b cnt=%0d err=%b expected 1010 0 0", fl, bus.shadow_count, bus.stack_err);
    end
    idle();
  endtask

  task automatic test_overflow();
    load_flags(4'b0001);
    bus.int_save = 1'b1;
    alu(4'b1111, 4'b0010);
    step();
    alu(4'b1111, 4'b0100);
    step();
    alu(4'b1111, 4'b1000);
    step();
    total++;
    if (bus.shadow_count !== 3'd2 || bus.stack_err !== 1'b1 || fl !== 4'b1000) begin
      bad++;
      $display("FAIL push_full: cnt=%0d err=%b flags=%b expected 2 1 1000", bus.shadow_count, bus.stack_err, fl);
    end
    idle();
    bus.rti_restore = 1'b1;
    bus.int_save    = 1'b1;
    bus.stall       = 1'b1;
    alu(4'b1111, 4'b1111);
    step();
    total++;
    if (fl !== 4'b0010 || bus.shadow_count !== 3'd1) begin
      bad++;
      $display("FAIL pop1: flags=%b cnt=%0d expected 0010 1", fl, bus.shadow_count);
    end
    idle();
    bus.rti_restore = 1'b1;
    step();
    total++;
    if (fl !== 4'b0001 || bus.shadow_count !== 3'd0) begin
      bad++;
      $display("FAIL pop2: flags=%b cnt=%0d expected 0001 0", fl, bus.shadow_count);
    end
    step();
    total++;
    if (fl !== 4'b0000 || bus.shadow_count !== 3'd0 || bus.stack_err !== 1'b1) begin
      bad++;
      $display("FAIL pop_empty: flags=%b cnt=%0d err=%b expected 0000 0 1", fl, bus.shadow_count, bus.stack_err);
    end
    idle();
  endtask

  task automatic test_stall_and_async_reset();
    load_flags(4'b0110);
    bus.int_save = 1'b1;
    step();
    idle();
    bus.stall    = 1'b1;
    bus.int_save = 1'b1;
    alu(4'b1111, 4'b1001);
    bus.setc = 1'b1;
    step();
    step();
    total++;
    if (fl !== 4'b0110 || bus.shadow_count !== 3'd1) begin
      bad++;
      $display("FAIL stall_hold: flags=%b cnt=%0d expected 0110 1", fl, bus.shadow_count);
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (fl !== 4'b0000 || bus.shadow_count !== 3'd0 || bus.stack_err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: flags=%b cnt=%0d err=%b expected 0000 0 0", fl, bus.shadow_count, bus.stack_err);
    end
    step();
    rst_n = 1'b1;
    bus.rti_restore = 1'b1;
    step();
    total++;
    if (fl !== 4'b0000 || bus.stack_err !== 1'b1) begin
      bad++;
      $display("FAIL stack_cleared_by_reset: flags=%b err=%b expected 0000 1", fl, bus.stack_err);
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    idle();
    test_reset();
    test_alu_write();
    test_setc_clrc();
    test_branch();
    test_save_restore();
    test_overflow();
    test_stall_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
Condition-code register (CCR) block for the 5-stage pipeline. It receives the flag results the ALU computes in EX and holds the architectural ZF/NF/CF/OVF state. It drives those flags back to the ALU as its original-flag inputs and to the branch unit. It also implements SETC/CLRC, clear-on-taken-branch, and a small shadow stack that saves flags on interrupt entry and restores them on RTI.

Parameters:
SHADOW_DEPTH, 2, number of nested interrupt flag snapshots held (1..4).

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline stall; when 1, CCR and stack hold
alu_we  in  4  per-flag write mask from EX control, bit order {OVF,CF,NF,ZF}
alu_zf / alu_nf / alu_cf / alu_ovf  in  1 each  flag results from the ALU this cycle
setc  in  1  SETC instruction in EX
clrc  in  1  CLRC instruction in EX
br_taken  in  1  conditional jump taken this cycle
br_sel  in  2  flag tested by that jump: 0=ZF, 1=NF, 2=CF, 3=reserved
int_save  in  1  interrupt entry: push current flags
rti_restore  in  1  RTI: pop flags
zf / nf / cf / ovf  out  1 each  registered CCR contents, fed to the ALU original-flag inputs and to the branch unit
shadow_count  out  3  number of valid shadow entries
stack_err  out  1  sticky: push when full or pop when empty

Behaviour:
- Reset (rst_n=0, async): zf=nf=cf=ovf=0, shadow_count=0, stack_err=0, all shadow entries 0. Reset mid-operation discards any pending save/restore.
- All outputs are registered. A flag written in cycle N is visible on the outputs from cycle N+1. There is no combinational bypass; forwarding is the hazard unit's job.
- Per-edge priority, highest first:
  1. rti_restore.
  2. stall.
  3. Normal update.
- rti_restore=1, stack non-empty: flags <= top entry; shadow_count decrements. All other inputs this cycle are ignored, including int_save and stall.
- rti_restore=1, stack empty: flags <= 0 and stack_err <= 1.
- stall=1 (and no restore): flags and stack hold. int_save is ignored; the control unit re-asserts it.
- Normal update. The next value of each flag bit is computed in this order, each step overriding the previous:
  a. Start from the current flags.
  b. Bits with alu_we set take the alu_* values.
  c. setc forces CF=1; clrc forces CF=0; setc&clrc together leaves CF unchanged from step b.
  d. br_taken clears the flag chosen by br_sel. br_sel=3 clears nothing.
- int_save=1 (no restore, no stall): push the CURRENT registered flags (pre-update value) onto the stack and increment shadow_count. The normal update of the register still applies in the same cycle.
- int_save=1 with shadow_count==SHADOW_DEPTH: the push is dropped, stack_err <= 1, and the register update still applies.
- Stack organisation: LIFO of 4-bit entries {ovf,cf,nf,zf}. shadow_count never exceeds SHADOW_DEPTH and never goes below 0.
- stack_err is cleared only by reset.
- alu_we=0, setc=clrc=br_taken=0, no save/restore: flags hold. This is the path used by MOV, NOP, loads and stores.

Test Plan:
- Reset, then alu_we=4'b1111 with alu {ovf,cf,nf,zf}=1,0,1,0 -> next cycle ovf=1 cf=0 nf=1 zf=0. Hold all inputs at 0 for 3 cycles -> flags unchanged.
- Flags=0000; alu_we=4'b0011, alu all 1s, setc=1 same cycle -> {ovf,cf,nf,zf}=0,1,1,1.
- Flags zf=1,cf=1; br_taken=1, br_sel=0, alu_we=0 -> zf=0, cf=1. Repeat with br_sel=3 -> no change.
- Flags=1010; int_save with alu_we=4'b1111, alu=0101 -> flags=0101, shadow_count=1. rti_restore -> flags=1010, shadow_count=0, stack_err=0.
- SHADOW_DEPTH=2: three int_saves -> shadow_count=2, stack_err=1. Three rti_restores -> first two pop in LIFO order, third gives flags=0000 with stack_err still 1.
- stall=1 with alu_we=4'b1111 and int_save=1 -> flags and shadow_count unchanged. Assert rst_n=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
